// File: rtl/aes_pkg.sv
// Shared AES definitions: MixColumns sequencer state encoding, widths and
// the GF(2^8) doubling primitive used by the column unit.
package aes_pkg;

    localparam int COL_W    = 32;
    localparam int STATE_W  = 128;
    localparam int NUM_COLS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MIX  = 2'd1,
        DONE = 2'd2
    } mc_state_t;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_columns_sequencer_galois.sv
// galoisMultiply: combinational MixColumns for one 32-bit column.
// Byte 0 of the column sits in the MSBs. 3*b is formed as xtime(b)^b.
module galoisMultiply
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] col_i,
    output logic [COL_W-1:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    // Circulant matrix rows {2,3,1,1}; all arithmetic stays 8 bits wide.
    assign col_o[31:24] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    assign col_o[7:0]   = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);

endmodule

// File: rtl/mix_columns_sequencer.sv
// mix_columns_sequencer: AES MixColumns over a 128-bit state, one column per
// clock through a single shared column unit. Final-round blocks may bypass.
module mix_columns_sequencer
    import aes_pkg::*;
#(
    parameter int NUM_COLS  = 4,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] inState,
    input  logic         inBypass,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] outState,
    output logic         busy,
    output logic [1:0]   colIdx
);

    generate
        if (NUM_COLS != 4) begin : g_bad_num_cols
            $error("mix_columns_sequencer: NUM_COLS must be 4");
        end
    endgenerate

    mc_state_t          state_q, state_d;
    logic [1:0]         col_q, col_d;
    logic [STATE_W-1:0] src_q, res_q;
    logic [COL_W-1:0]   mix_in, mix_out;
    logic [6:0]         col_lsb;
    logic               take_bypass;

    // With BYPASS_EN clear the inBypass pin never reaches the FSM.
    assign take_bypass = BYPASS_EN && inBypass;

    // Column c lives at bits [127-32c -: 32]; (3-c) on 2 bits is ~c.
    assign col_lsb = {~col_q, 5'd0};
    assign mix_in  = src_q[col_lsb +: COL_W];

    galoisMultiply u_col (
        .col_i (mix_in),
        .col_o (mix_out)
    );

    // Next-state: accept in IDLE, walk four columns in MIX, hold in DONE.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        case (state_q)
            IDLE: begin
                if (inValid) begin
                    state_d = take_bypass ? DONE : MIX;
                    col_d   = 2'd0;
                end
            end
            MIX: begin
                if (col_q == 2'd3) begin
                    state_d = DONE;
                    col_d   = 2'd0;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            DONE: begin
                if (outReady) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                col_d   = 2'd0;
            end
        endcase
    end

    // FSM state and column counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    // Source capture on accept; result filled column by column (or whole on bypass).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q <= '0;
            res_q <= '0;
        end else if (state_q == IDLE && inValid) begin
            src_q <= inState;
            if (take_bypass) res_q <= inState;
        end else if (state_q == MIX) begin
            res_q[col_lsb +: COL_W] <= mix_out;
        end
    end

    // Result is gated to DONE so a half-written state is never visible.
    assign inReady  = (state_q == IDLE) && !rst;
    assign outValid = (state_q == DONE);
    assign outState = outValid ? res_q : '0;
    assign busy     = (state_q != IDLE);
    assign colIdx   = (state_q == MIX) ? col_q : 2'd0;

endmodule
